// File: rtl/ysyx_wbu_commit_pkg.sv
// Shared types and constants for the write-back / commit stage.
// Covers the held-entry layout, CSR mask bits and FSM state encoding.
package ysyx_wbu_commit_pkg;

    localparam int          WBU_XLEN         = 32;
    localparam logic [31:0] WBU_EBREAK_INST  = 32'h0010_0073;
    localparam logic [31:0] WBU_MCAUSE_ECALL = 32'd11;

    // Bit positions inside csr_wen and inside the packed CSR array.
    localparam int CSR_MSTATUS = 0;
    localparam int CSR_MTVEC   = 1;
    localparam int CSR_MEPC    = 2;
    localparam int CSR_MCAUSE  = 3;
    localparam logic [3:0] CSR_ECALL_MASK = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_HALT   = 2'd2
    } wbu_state_e;

    typedef struct packed {
        logic [31:0]         pc;
        logic [31:0]         inst;
        logic                r_wen;
        logic [4:0]          rd;
        logic                mem_ren;
        logic [WBU_XLEN-1:0] lsu_rdata;
        logic [WBU_XLEN-1:0] ex_result;
        logic [WBU_XLEN-1:0] csrs;
        logic [3:0]          csr_wen;
    } wbu_entry_t;

    // Load data beats CSR old value, which beats the ALU result.
    function automatic logic [WBU_XLEN-1:0] wb_data(input wbu_entry_t e);
        if (e.mem_ren)        return e.lsu_rdata;
        else if (|e.csr_wen)  return e.csrs;
        else                  return e.ex_result;
    endfunction

endpackage

// File: rtl/ysyx_wbu_commit_if.sv
// Handshake and payload from the load/store stage into write-back.
interface ysyx_wbu_commit_if;
    logic        valid_last;
    logic        ready_last;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        R_wen;
    logic [4:0]  rd;
    logic        mem_ren;
    logic [31:0] LSU_Rdata;
    logic [31:0] Ex_result;
    logic [31:0] csrs;
    logic [3:0]  csr_wen;

    modport master (
        output valid_last, pc, inst, R_wen, rd, mem_ren, LSU_Rdata, Ex_result, csrs, csr_wen,
        input  ready_last
    );

    modport slave (
        input  valid_last, pc, inst, R_wen, rd, mem_ren, LSU_Rdata, Ex_result, csrs, csr_wen,
        output ready_last
    );
endinterface

// File: rtl/ysyx_wbu_commit_regfile.sv
// Architectural GPR file: one write port, two combinational read ports,
// x0 hard-wired to zero, and write-through so decode sees commit data early.
module ysyx_wbu_regfile #(
    parameter int XLEN   = 32,
    parameter int NR_REG = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      we,
    input  logic [4:0]                waddr,
    input  logic [XLEN-1:0]           wdata,
    input  logic [1:0][4:0]           raddr,
    output logic [1:0][XLEN-1:0]      rdata
);
    localparam int IDX_W = $clog2(NR_REG);

    logic [XLEN-1:0] regs_q [NR_REG];
    logic [XLEN-1:0] regs_d [NR_REG];
    logic            wr_ok;

    // Indices beyond NR_REG (e.g. x16..x31 on RV32E) are silently dropped.
    always_comb begin
        wr_ok  = we && (waddr != 5'd0) && (32'(waddr) < NR_REG);
        regs_d = regs_q;
        if (wr_ok) regs_d[waddr[IDX_W-1:0]] = wdata;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NR_REG; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        always_comb begin
            rdata[p] = '0;
            if (raddr[p] != 5'd0 && 32'(raddr[p]) < NR_REG) begin
                if (wr_ok && waddr == raddr[p]) rdata[p] = wdata;
                else                            rdata[p] = regs_q[raddr[p][IDX_W-1:0]];
            end
        end
    end

endmodule

// File: rtl/ysyx_wbu_commit.sv
// Write-back / commit stage: holds one retiring instruction, commits it the
// following cycle to GPRs and machine CSRs, and halts the core on ebreak.
module ysyx_wbu_commit
    import ysyx_wbu_commit_pkg::*;
#(
    parameter int          XLEN         = WBU_XLEN,
    parameter int          NR_REG       = 16,
    parameter logic [31:0] EBREAK_INST  = WBU_EBREAK_INST,
    parameter logic [31:0] MCAUSE_ECALL = WBU_MCAUSE_ECALL
) (
    input  logic                 clock,
    input  logic                 reset,
    ysyx_wbu_commit_if.slave     up,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    output logic [XLEN-1:0]      rs1_value,
    output logic [XLEN-1:0]      rs2_value,
    output logic                 pend_valid,
    output logic [4:0]           pend_rd,
    output logic [XLEN-1:0]      mstatus,
    output logic [XLEN-1:0]      mtvec,
    output logic [XLEN-1:0]      mepc,
    output logic [XLEN-1:0]      mcause,
    output logic                 retire,
    output logic [31:0]          retire_pc,
    output logic [31:0]          retire_inst,
    output logic [63:0]          instret,
    output logic                 halt
);
    wbu_state_e             state_q, state_d;
    wbu_entry_t             entry_q, entry_d;
    logic [3:0][XLEN-1:0]   csr_q, csr_d;
    logic [63:0]            instret_q, instret_d;

    logic                   committing, is_ebreak, is_ecall, ready, accept;
    logic                   gpr_we;
    logic [XLEN-1:0]        gpr_wdata;

    always_comb begin
        committing = (state_q == ST_COMMIT);
        is_ebreak  = committing && (entry_q.inst == EBREAK_INST);
        is_ecall   = (entry_q.csr_wen == CSR_ECALL_MASK);
        // The ebreak commit cycle must not accept: nothing may follow it.
        ready      = (state_q == ST_IDLE) || (committing && !is_ebreak);
        accept     = up.valid_last && ready;
        gpr_we     = committing && entry_q.r_wen && (entry_q.rd != 5'd0) && !is_ecall;
        gpr_wdata  = wb_data(entry_q);

        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept) state_d = ST_COMMIT;
            ST_COMMIT: if (is_ebreak)   state_d = ST_HALT;
                       else if (!accept) state_d = ST_IDLE;
            default:   state_d = ST_HALT;
        endcase

        entry_d = entry_q;
        if (accept) begin
            entry_d.pc        = up.pc;
            entry_d.inst      = up.inst;
            entry_d.r_wen     = up.R_wen;
            entry_d.rd        = up.rd;
            entry_d.mem_ren   = up.mem_ren;
            entry_d.lsu_rdata = up.LSU_Rdata;
            entry_d.ex_result = up.Ex_result;
            entry_d.csrs      = up.csrs;
            entry_d.csr_wen   = up.csr_wen;
        end

        csr_d     = csr_q;
        instret_d = instret_q;
        if (committing) begin
            instret_d = instret_q + 64'd1;
            if (is_ecall) begin
                csr_d[CSR_MEPC]   = entry_q.pc;
                csr_d[CSR_MCAUSE] = MCAUSE_ECALL;
            end else begin
                for (int i = 0; i < 4; i++)
                    if (entry_q.csr_wen[i]) csr_d[i] = entry_q.ex_result;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            entry_q   <= '0;
            csr_q     <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            entry_q   <= entry_d;
            csr_q     <= csr_d;
            instret_q <= instret_d;
        end
    end

    ysyx_wbu_regfile #(.XLEN(XLEN), .NR_REG(NR_REG)) u_regfile (
        .clock (clock),
        .reset (reset),
        .we    (gpr_we),
        .waddr (entry_q.rd),
        .wdata (gpr_wdata),
        .raddr ({rs2_addr, rs1_addr}),
        .rdata ({rs2_value, rs1_value})
    );

    assign up.ready_last = ready;
    assign pend_valid    = committing && entry_q.r_wen && (entry_q.rd != 5'd0);
    assign pend_rd       = entry_q.rd;
    assign mstatus       = csr_q[CSR_MSTATUS];
    assign mtvec         = csr_q[CSR_MTVEC];
    assign mepc          = csr_q[CSR_MEPC];
    assign mcause        = csr_q[CSR_MCAUSE];
    assign retire        = committing;
    assign retire_pc     = entry_q.pc;
    assign retire_inst   = entry_q.inst;
    assign instret       = instret_q;
    assign halt          = (state_q == ST_HALT);

endmodule

// File: tb/tb_ysyx_wbu_commit.sv
// Directed bench for the commit stage: table of single-entry commits,
// then back-to-back, out-of-range rd, ebreak/halt and reset sequences.
module tb_ysyx_wbu_commit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  rs1_addr = 5'd0, rs2_addr = 5'd0;
    logic [31:0] rs1_value, rs2_value, mstatus, mtvec, mepc, mcause, retire_pc, retire_inst;
    logic        pend_valid, retire, halt;
    logic [4:0]  pend_rd;
    logic [63:0] instret;

    int n_pass = 0;
    int n_total = 0;

    ysyx_wbu_commit_if u_if();

    ysyx_wbu_commit dut (
        .clock(clock), .reset(reset), .up(u_if.slave),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_value(rs1_value), .rs2_value(rs2_value),
        .pend_valid(pend_valid), .pend_rd(pend_rd),
        .mstatus(mstatus), .mtvec(mtvec), .mepc(mepc), .mcause(mcause),
        .retire(retire), .retire_pc(retire_pc), .retire_inst(retire_inst),
        .instret(instret), .halt(halt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc, inst;
        logic        r_wen;
        logic [4:0]  rd;
        logic        mem_ren;
        logic [31:0] lsu, ex, csrs;
        logic [3:0]  csr_wen;
        logic [4:0]  chk_rd;
        logic [31:0] exp_rd, exp_mstatus, exp_mtvec, exp_mepc, exp_mcause;
        logic [63:0] exp_instret;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic r_wen, input logic [4:0] rd, input logic mem_ren,
                         input logic [31:0] lsu, input logic [31:0] ex, input logic [31:0] csrs,
                         input logic [3:0] csr_wen);
        u_if.valid_last = v;     u_if.pc = pc;          u_if.inst = inst;
        u_if.R_wen = r_wen;      u_if.rd = rd;          u_if.mem_ren = mem_ren;
        u_if.LSU_Rdata = lsu;    u_if.Ex_result = ex;   u_if.csrs = csrs;
        u_if.csr_wen = csr_wen;
    endtask

    task automatic idle_in();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0);
    endtask

    logic [4:0]  b2b_rd [5];
    logic [31:0] b2b_ex [5];
    int          n_retire;

    initial begin
        vecs[0] = '{32'h8000_0000, 32'h0050_0293, 1'b1, 5'd5, 1'b0, 32'h0, 32'h0000_1234, 32'h0,
                    4'b0000, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 32'h0, 64'd1};
        vecs[1] = '{32'h8000_0004, 32'h0000_2183, 1'b1, 5'd3, 1'b1, 32'hFFFF_FF80, 32'h8000_0004, 32'h0,
                    4'b0000, 5'd3, 32'hFFFF_FF80, 32'h0, 32'h0, 32'h0, 32'h0, 64'd2};
        vecs[2] = '{32'h8000_0008, 32'h3050_9373, 1'b1, 5'd6, 1'b0, 32'h0, 32'h8000_0100, 32'h0,
                    4'b0010, 5'd6, 32'h0, 32'h0, 32'h8000_0100, 32'h0, 32'h0, 64'd3};
        vecs[3] = '{32'h8000_000C, 32'h3000_93F3, 1'b1, 5'd7, 1'b0, 32'h0, 32'h0000_1800, 32'h0000_ABCD,
                    4'b0001, 5'd7, 32'h0000_ABCD, 32'h0000_1800, 32'h8000_0100, 32'h0, 32'h0, 64'd4};
        // ecall with R_wen/rd set: GPR write must be suppressed, x5 keeps 0x1234
        vecs[4] = '{32'h8000_0040, 32'h0000_0073, 1'b1, 5'd5, 1'b0, 32'h0, 32'h0000_0099, 32'h0000_0077,
                    4'b1100, 5'd5, 32'h0000_1234, 32'h0000_1800, 32'h8000_0100, 32'h8000_0040, 32'd11, 64'd5};
        vecs[5] = '{32'h8000_0044, 32'h3420_1473, 1'b1, 5'd8, 1'b0, 32'h0, 32'h0000_0002, 32'h0000_000B,
                    4'b1000, 5'd8, 32'h0000_000B, 32'h0000_1800, 32'h8000_0100, 32'h8000_0040, 32'h2, 64'd6};

        b2b_rd = '{5'd9, 5'd10, 5'd0, 5'd11, 5'd12};
        b2b_ex = '{32'h91, 32'hA1, 32'h7, 32'hB1, 32'hC1};

        idle_in();
        #12;
        chk("rst_ready", {63'd0, u_if.ready_last}, 64'd1);
        chk("rst_retire", {63'd0, retire}, 64'd0);
        chk("rst_halt", {63'd0, halt}, 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_pend", {63'd0, pend_valid}, 64'd0);
        chk("rst_csrs", {32'd0, mstatus | mtvec | mepc | mcause}, 64'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].pc, vecs[i].inst, vecs[i].r_wen, vecs[i].rd, vecs[i].mem_ren,
                  vecs[i].lsu, vecs[i].ex, vecs[i].csrs, vecs[i].csr_wen);
            tick();
            idle_in();
            rs1_addr = vecs[i].chk_rd;
            #1;
            chk($sformatf("v%0d_retire", i), {63'd0, retire}, 64'd1);
            chk($sformatf("v%0d_retire_pc", i), {32'd0, retire_pc}, {32'd0, vecs[i].pc});
            chk($sformatf("v%0d_retire_inst", i), {32'd0, retire_inst}, {32'd0, vecs[i].inst});
            chk($sformatf("v%0d_bypass", i), {32'd0, rs1_value}, {32'd0, vecs[i].exp_rd});
            chk($sformatf("v%0d_pend", i), {58'd0, pend_valid, pend_rd},
                {58'd0, vecs[i].r_wen && vecs[i].rd != 5'd0, vecs[i].rd});
            chk($sformatf("v%0d_ready", i), {63'd0, u_if.ready_last}, 64'd1);
            tick();
            chk($sformatf("v%0d_retire_off", i), {63'd0, retire}, 64'd0);
            chk($sformatf("v%0d_gpr", i), {32'd0, rs1_value}, {32'd0, vecs[i].exp_rd});
            chk($sformatf("v%0d_mstatus", i), {32'd0, mstatus}, {32'd0, vecs[i].exp_mstatus});
            chk($sformatf("v%0d_mtvec", i), {32'd0, mtvec}, {32'd0, vecs[i].exp_mtvec});
            chk($sformatf("v%0d_mepc", i), {32'd0, mepc}, {32'd0, vecs[i].exp_mepc});
            chk($sformatf("v%0d_mcause", i), {32'd0, mcause}, {32'd0, vecs[i].exp_mcause});
            chk($sformatf("v%0d_instret", i), instret, vecs[i].exp_instret);
        end

        // rd beyond NR_REG must not alias onto x4
        drive(1'b1, 32'h8000_0048, 32'h0550_0A13, 1'b1, 5'd20, 1'b0, 32'h0, 32'h55, 32'h0, 4'b0);
        tick();
        idle_in();
        tick();
        rs1_addr = 5'd4;
        rs2_addr = 5'd0;
        #1;
        chk("oor_x4", {32'd0, rs1_value}, 64'd0);
        chk("oor_instret", instret, 64'd7);

        // five back-to-back entries, one targeting x0
        n_retire = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h8000_0100 + 32'(i * 4), 32'h0000_0013, 1'b1, b2b_rd[i], 1'b0,
                  32'h0, b2b_ex[i], 32'h0, 4'b0);
            if (i > 0) rs1_addr = b2b_rd[i-1];
            #1;
            chk($sformatf("b2b_ready%0d", i), {63'd0, u_if.ready_last}, 64'd1);
            if (i > 0) begin
                if (retire) n_retire++;
                chk($sformatf("b2b_bypass%0d", i), {32'd0, rs1_value},
                    {32'd0, (b2b_rd[i-1] == 5'd0) ? 32'h0 : b2b_ex[i-1]});
            end
            tick();
        end
        idle_in();
        rs1_addr = b2b_rd[4];
        #1;
        if (retire) n_retire++;
        chk("b2b_bypass4", {32'd0, rs1_value}, {32'd0, b2b_ex[4]});
        tick();
        if (retire) n_retire++;
        chk("b2b_retires", 64'(n_retire), 64'd5);
        chk("b2b_instret", instret, 64'd12);
        rs1_addr = 5'd0;
        rs2_addr = 5'd9;
        #1;
        chk("b2b_x0", {32'd0, rs1_value}, 64'd0);
        chk("b2b_x9", {32'd0, rs2_value}, 64'h91);

        // ebreak: retires, blocks upstream, then halts for good
        drive(1'b1, 32'h8000_0200, 32'h0010_0073, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0);
        tick();
        drive(1'b1, 32'h8000_0204, 32'h0000_0013, 1'b1, 5'd13, 1'b0, 32'h0, 32'hDEAD, 32'h0, 4'b0);
        rs1_addr = 5'd13;
        #1;
        chk("ebk_retire", {63'd0, retire}, 64'd1);
        chk("ebk_retire_pc", {32'd0, retire_pc}, 64'h8000_0200);
        chk("ebk_ready", {63'd0, u_if.ready_last}, 64'd0);
        chk("ebk_halt_early", {63'd0, halt}, 64'd0);
        tick();
        chk("ebk_halt", {63'd0, halt}, 64'd1);
        chk("ebk_instret", instret, 64'd13);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("halt_hold%0d", c), {61'd0, halt, retire, u_if.ready_last}, 64'b100);
        end
        chk("halt_x13", {32'd0, rs1_value}, 64'd0);
        chk("halt_instret", instret, 64'd13);

        // reset while halted and upstream still valid
        reset = 1'b0;
        #1;
        chk("rst2_halt", {63'd0, halt}, 64'd0);
        chk("rst2_instret", instret, 64'd0);
        rs1_addr = 5'd5;
        #1;
        chk("rst2_x5", {32'd0, rs1_value}, 64'd0);
        idle_in();
        tick();
        reset = 1'b1;
        tick();
        drive(1'b1, 32'h8000_0000, 32'h0420_0293, 1'b1, 5'd5, 1'b0, 32'h0, 32'h42, 32'h0, 4'b0);
        tick();
        idle_in();
        #1;
        chk("post_rst_retire", {63'd0, retire}, 64'd1);
        tick();
        chk("post_rst_x5", {32'd0, rs1_value}, 64'h42);
        chk("post_rst_instret", instret, 64'd1);

        // reset in the middle of a commit cycle drops the pending write
        drive(1'b1, 32'h8000_0004, 32'h0770_0713, 1'b1, 5'd14, 1'b0, 32'h0, 32'h77, 32'h0, 4'b0);
        tick();
        idle_in();
        rs1_addr = 5'd14;
        reset = 1'b0;
        #1;
        chk("midc_retire", {63'd0, retire}, 64'd0);
        chk("midc_instret", instret, 64'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("midc_x14", {32'd0, rs1_value}, 64'd0);
        chk("midc_ready", {63'd0, u_if.ready_last}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ysyx_wbu_commit.md
Name: ysyx_wbu_commit

Overview:
- Write-back/commit stage directly downstream of the load/store stage in the in-order RV32 pipeline.
- Accepts one retiring instruction per handshake and holds it in a one-entry register.
- On the following cycle it writes the GPR file and the machine CSRs, and reports retirement.
- Owns the architectural register file; exposes combinational GPR read ports and hazard info to decode, and halts the core on ebreak.

Parameters:
- XLEN, 32, datapath width.
- NR_REG, 16, GPR count (16 = RV32E, 32 = RV32I); register index width is log2(NR_REG).
- EBREAK_INST, 32'h00100073, encoding that triggers HALT.
- MCAUSE_ECALL, 32'd11, mcause value written on ecall.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- valid_last  in  1  upstream entry valid.
- ready_last  out  1  stage can accept.
- pc  in  32  instruction PC.
- inst  in  32  instruction word.
- R_wen  in  1  GPR write enable.
- rd  in  5  destination register.
- mem_ren  in  1  instruction was a load.
- LSU_Rdata  in  32  extended load data.
- Ex_result  in  32  ALU result / new CSR value.
- csrs  in  32  old CSR value (rd data for CSR ops).
- csr_wen  in  4  CSR write mask: bit0 mstatus, bit1 mtvec, bit2 mepc, bit3 mcause.
- rs1_addr, rs2_addr  in  5  decode read addresses.
- rs1_value, rs2_value  out  32  combinational GPR read data.
- pend_valid  out  1  held entry will write a GPR.
- pend_rd  out  5  its destination register.
- mstatus, mtvec, mepc, mcause  out  32  CSR contents.
- retire  out  1  one-cycle commit pulse.
- retire_pc, retire_inst  out  32  committed instruction.
- instret  out  64  retired-instruction count.
- halt  out  1  sticky, set on ebreak commit.

Behaviour:
- Async reset (reset=0) clears all of the following: GPRs, CSRs, instret, held entry, retire, halt, pend_valid, retire_pc, retire_inst. Reset puts the FSM in IDLE and sets ready_last=1. Reset is honoured mid-COMMIT; the pending write is discarded.
- FSM states: IDLE, COMMIT, HALT.
  - IDLE: valid_last & ready_last latches all inputs and moves to COMMIT.
  - COMMIT: performs the writes below for one cycle. A new valid_last in the same cycle latches the next entry (stay in COMMIT), giving back-to-back throughput of 1/cycle. No valid_last moves to IDLE. A held inst==EBREAK_INST moves to HALT regardless of valid_last.
  - HALT: terminal until reset.
- ready_last:
  - IDLE, COMMIT: ready_last=1, except it is 0 in the COMMIT cycle of an ebreak.
  - HALT: ready_last=0.
- Latency: entry accepted at edge T; writes occur at edge T+1. retire is high during cycle T+1 with retire_pc and retire_inst of the entry.
- GPR write data:
  - mem_ren: LSU_Rdata.
  - else if csr_wen!=0: csrs.
  - else: Ex_result.
  - Written only if R_wen and rd!=0; rd>=NR_REG is ignored.
- CSR write:
  - Each set csr_wen bit writes Ex_result to that CSR.
  - Exception: csr_wen==4'b1100 is ecall. mepc<=pc, mcause<=MCAUSE_ECALL, GPR write suppressed.
- Read ports:
  - x0 always reads 0.
  - Write-through bypass: a read of the register being written in the COMMIT cycle returns the new data.
- Hazard outputs: pend_valid = held entry valid & R_wen & rd!=0, else 0. pend_rd = held rd.
- instret increments by 1 per retire, wraps at 2^64-1 to 0.
- ebreak commits (retire=1, instret++), then halt=1 from the next cycle.

Decomposition:
- Shared package: CSR mask bit positions, EBREAK_INST, MCAUSE_ECALL, FSM state encoding.
- Sub-module ysyx_wbu_regfile: NR_REG x XLEN registers, 1 write port, 2 read ports, x0 hard zero, write-through bypass.

Test Plan:
- Write then read: addi-like entry R_wen=1, rd=5, Ex_result=32'h1234 -> retire at T+1; rs1_addr=5 reads 32'h1234 in the same cycle via bypass and afterwards; instret=1.
- Load select: mem_ren=1, LSU_Rdata=32'hFFFFFF80, Ex_result=32'h8000_0004, rd=3 -> x3=32'hFFFFFF80.
- CSR path: csr_wen=4'b0010, Ex_result=32'h8000_0100, csrs=32'h0, rd=6 -> mtvec=32'h8000_0100, x6=0.
- Ecall: csr_wen=4'b1100, pc=32'h8000_0040, rd=0 -> mepc=32'h8000_0040, mcause=11, no GPR change.
- Back-to-back and x0: five consecutive valid entries, one with rd=0, Ex_result=7 -> ready_last stays 1, five retire pulses, x0 reads 0, instret=5.
- Ebreak: inst=32'h00100073 -> retire pulse, ready_last=0, halt=1 next cycle and held. Further valid_last is ignored. Pulling reset low mid-stream clears halt and instret; the next entry commits normally.
